// File: rtl/seven_seg_scan_if.sv
// Display-scanner bus: value/control from the host side, scanned nibble and anodes back out.
interface seven_seg_scan_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value_i;
    logic                    load_i;
    logic                    enable_i;
    logic                    blank_lz_i;
    logic [3:0]              nibble_o;
    logic [NUM_DIGITS-1:0]   digit_an_o;
    logic [2:0]              digit_idx_o;

    modport master (
        output value_i, load_i, enable_i, blank_lz_i,
        input  nibble_o, digit_an_o, digit_idx_o
    );

    modport slave (
        input  value_i, load_i, enable_i, blank_lz_i,
        output nibble_o, digit_an_o, digit_idx_o
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scanner: shadow-latched value, per-slot dead time, leading-zero
// blanking, fully registered nibble/anode/index outputs with one cycle of latency.
module seven_seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned DEAD_CYC    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    seven_seg_scan_if.slave  bus
);
    localparam int unsigned DATA_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_END = CNT_W'(DEAD_CYC);
    localparam logic [2:0]       IDX_MAX  = 3'(NUM_DIGITS - 1);

    logic [DATA_W-1:0]     shadow_q, shadow_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [3:0]            nibble_q, nibble_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic [2:0]            idx_out_q, idx_out_d;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  upper_zero;

    // Shadow register and slot/digit scan state.
    always_comb begin
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        if (bus.load_i) begin
            shadow_d = bus.value_i;
        end
        if (!bus.enable_i) begin
            cnt_d = '0;
            idx_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Digit k is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        upper_zero = 1'b1;
        blank_mask = '0;
        for (int k = int'(NUM_DIGITS) - 1; k >= 0; k--) begin
            upper_zero    = upper_zero & (shadow_q[4*k +: 4] == 4'h0);
            blank_mask[k] = bus.blank_lz_i & upper_zero & (k != 0);
        end
    end

    always_comb begin
        nibble_d  = '0;
        an_d      = '1;
        idx_out_d = idx_q;
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (idx_q == 3'(k)) begin
                nibble_d = shadow_q[4*k +: 4];
                if (bus.enable_i && (cnt_q >= DEAD_END) && !blank_mask[k]) begin
                    an_d[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            nibble_q  <= '0;
            an_q      <= '1;
            idx_out_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            nibble_q  <= nibble_d;
            an_q      <= an_d;
            idx_out_q <= idx_out_d;
        end
    end

    assign bus.nibble_o    = nibble_q;
    assign bus.digit_an_o  = an_q;
    assign bus.digit_idx_o = idx_out_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: arithmetic display model checked every cycle plus
// hand-computed literal expectations for the directed scenarios.
module tb_seven_seg_scan_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned RD = 4;
    localparam int unsigned DC = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seven_seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .REFRESH_DIV(RD),
        .DEAD_CYC   (DC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model: shadow value and cycle position within the 16-cycle scan period.
    logic [15:0] m_shadow = '0;
    int          m_p = 0;
    logic [3:0]  e_nib;
    logic [3:0]  e_an;
    logic [2:0]  e_idx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int   d;
        int   ph;
        logic lz;
        if (!rst_n) begin
            m_shadow = '0;
            m_p      = 0;
            e_nib    = '0;
            e_an     = 4'hF;
            e_idx    = '0;
        end else begin
            d     = (m_p / RD) % N;
            ph    = m_p % RD;
            e_idx = 3'(d);
            e_nib = 4'((m_shadow >> (4 * d)) & 16'hF);
            lz    = bus.blank_lz_i && (d != 0) && ((m_shadow >> (4 * d)) == 16'h0);
            e_an  = (bus.enable_i && ph >= int'(DC) && !lz) ? ~(4'b0001 << d) : 4'hF;
            if (bus.load_i) m_shadow = bus.value_i;
            m_p = bus.enable_i ? (m_p + 1) % int'(N * RD) : 0;
        end
    endtask

    // One clock: model consumes current inputs, DUT clocks, outputs compared mid-cycle.
    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("nibble", bus.nibble_o, e_nib);
        chk("anodes", bus.digit_an_o, e_an);
        chk("digit_idx", bus.digit_idx_o, e_idx);
        chk("one_low", ($countones(~bus.digit_an_o) <= 1), 1);
    endtask

    task automatic load_cyc(input logic [15:0] v);
        bus.load_i  = 1'b1;
        bus.value_i = v;
        cyc();
        bus.load_i  = 1'b0;
    endtask

    logic [3:0] scan_an  [17] = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD, 4'hD, 4'hD, 4'hF,
                                  4'hB, 4'hB, 4'hB, 4'hF, 4'h7, 4'h7, 4'h7, 4'hF};
    logic [3:0] scan_nib [17] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2,
                                  4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1, 4'h4};
    logic [3:0] seen;
    logic       found;

    initial begin
        bus.value_i    = 16'hFFFF;
        bus.load_i     = 1'b1;
        bus.enable_i   = 1'b0;
        bus.blank_lz_i = 1'b0;
        rst_n          = 1'b0;

        // Reset dominates a pending load.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("rst_an", bus.digit_an_o, 4'hF);
            chk("rst_nib", bus.nibble_o, 4'h0);
        end
        rst_n = 1'b1;
        load_cyc(16'h0000);
        bus.enable_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("post_rst_nib", bus.nibble_o, 4'h0);
        end

        // Scan 16'h1234 from a fresh slot.
        bus.enable_i = 1'b0;
        cyc();
        bus.enable_i = 1'b1;
        load_cyc(16'h1234);
        chk("scan_an0", bus.digit_an_o, scan_an[0]);
        chk("scan_nib0", bus.nibble_o, scan_nib[0]);
        for (int i = 1; i < 17; i++) begin
            cyc();
            chk("scan_an", bus.digit_an_o, scan_an[i]);
            chk("scan_nib", bus.nibble_o, scan_nib[i]);
        end
        for (int i = 0; i < 16; i++) cyc();

        // Leading-zero blanking.
        bus.blank_lz_i = 1'b1;
        load_cyc(16'h0050);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            seen = seen | ~bus.digit_an_o;
        end
        chk("lz_0050_lit", seen, 4'b0011);
        load_cyc(16'h0000);
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            cyc();
            seen = seen | ~bus.digit_an_o;
            chk("lz_0000_nib", bus.nibble_o, 4'h0);
        end
        chk("lz_0000_lit", seen, 4'b0001);

        // Enable toggle in the middle of the digit-2 slot.
        bus.blank_lz_i = 1'b0;
        load_cyc(16'h1234);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (bus.digit_idx_o == 3'd2 && bus.digit_an_o == 4'hB) found = 1'b1;
            else cyc();
        end
        chk("find_slot2", found, 1'b1);
        bus.enable_i = 1'b0;
        cyc();
        chk("dis_an", bus.digit_an_o, 4'hF);
        bus.enable_i = 1'b1;
        cyc();
        chk("reen_dead_an", bus.digit_an_o, 4'hF);
        chk("reen_dead_idx", bus.digit_idx_o, 3'd0);
        cyc();
        chk("reen_an", bus.digit_an_o, 4'hE);
        chk("reen_idx", bus.digit_idx_o, 3'd0);
        chk("reen_nib", bus.nibble_o, 4'h4);

        // Load coinciding with the slot boundary at div_cnt=3, idx=1.
        bus.enable_i = 1'b0;
        cyc();
        bus.enable_i = 1'b1;
        for (int i = 0; i < 7; i++) cyc();
        load_cyc(16'hABCD);
        chk("bnd_old_an", bus.digit_an_o, 4'hD);
        chk("bnd_old_nib", bus.nibble_o, 4'h3);
        cyc();
        chk("bnd_dead_an", bus.digit_an_o, 4'hF);
        chk("bnd_idx", bus.digit_idx_o, 3'd2);
        chk("bnd_new_nib", bus.nibble_o, 4'hB);
        cyc();
        chk("bnd_lit_an", bus.digit_an_o, 4'hB);
        chk("bnd_lit_nib", bus.nibble_o, 4'hB);

        // Random traffic, model and single-low-anode check every cycle.
        for (int i = 0; i < 3000; i++) begin
            rst_n          = ($urandom_range(0, 149) != 0);
            bus.load_i     = ($urandom_range(0, 7) == 0);
            bus.value_i    = 16'($urandom) & 16'($urandom);
            bus.enable_i   = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 31) == 0) bus.blank_lz_i = ~bus.blank_lz_i;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
